bcd_seq_converter: RTL and testbench

Sequential binary-to-BCD converter that extends our single-nibble decimal-to-BCD path to arbitrary input widths. It sequences shift-and-add-3 (double-dabble) iterations over a WIDTH-bit binary operand and produces DIGITS packed BCD digits. A start/busy/done handshake lets display and reporting logic share one converter instead of instantiating wide combinational trees. With WIDTH=4, DIGITS=2 its result equals the existing nibble converter's tens/units pair.

---
 rtl/bcd_seq_converter.sv | 95 +++++++++
 tb/tb_bcd_seq_converter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential double-dabble binary-to-BCD converter
// One iteration costs two cycles (ADJUST then SHIFT), so a WIDTH-bit operand takes 2*WIDTH cycles.
module bcd_seq_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADJUST = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state;
   logic [WIDTH-1:0]      bin_sr;
   logic [4*DIGITS-1:0]   scr;
   logic [4*DIGITS-1:0]   scr_adj;
   logic [4*DIGITS-1:0]   scr_shift;
   logic [CW-1:0]         cnt;

   // Each digit is corrected independently; carries never cross digit boundaries.
   always_comb begin
      scr_adj = scr;
      for (int k = 0; k < DIGITS; k++) begin
         if (scr[4*k +: 4] >= 4'd5) begin
            scr_adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
         end
      end
   end

   assign scr_shift = {scr[4*DIGITS-2:0], bin_sr[WIDTH-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bin_sr <= '0;
         scr    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         bcd    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  bin_sr <= bin;
                  scr    <= '0;
                  cnt    <= CW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= ADJUST;
               end
            end
            ADJUST: begin
               scr   <= scr_adj;
               state <= SHIFT;
            end
            SHIFT: begin
               scr    <= scr_shift;
               bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bcd   <= scr_shift;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= ADJUST;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - directed bench for bcd_seq_converter (8-bit and 4-bit instances)
module tb_bcd_seq_converter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bin = 8'd0;
   logic        busy, done;
   logic [11:0] bcd;

   logic        start4 = 1'b0;
   logic [3:0]  bin4 = 4'd0;
   logic        busy4, done4;
   logic [7:0]  bcd4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd)
   );

   bcd_seq_converter #(.WIDTH(4), .DIGITS(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
      .busy(busy4), .done(done4), .bcd(bcd4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic convert8(input logic [7:0] b, input logic [11:0] exp, input string tag);
      int n;
      start = 1'b1;
      bin   = b;
      tick();
      start = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (done) break;
      end
      check({tag, "_latency"}, 32'(n), 32'd16);
      check({tag, "_bcd"}, 32'(bcd), 32'(exp));
      tick();
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   task automatic convert4(input logic [3:0] b, input logic [7:0] exp, input string tag);
      int n;
      start4 = 1'b1;
      bin4   = b;
      tick();
      start4 = 1'b0;
      n = 0;
      while (n < 30) begin
         tick();
         n++;
         if (done4) break;
      end
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_bcd"}, 32'(bcd4), 32'(exp));
      tick();
      check({tag, "_done_drop"}, 32'(done4), 32'd0);
   endtask

   initial begin
      int n;
      int dones;

      // reset held with start asserted
      start = 1'b1;
      bin   = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_bcd", 32'(bcd), 32'd0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      convert8(8'd0, 12'h000, "zero");

      convert8(8'd255, 12'h255, "b255");
      convert8(8'd99, 12'h099, "b99");
      convert8(8'd100, 12'h100, "b100");

      for (int v = 0; v < 256; v++) begin
         convert8(8'(v), ref_bcd(v), "sweep");
      end

      // start re-asserted while busy must be ignored
      start = 1'b1;
      bin   = 8'd42;
      tick();
      start = 1'b0;
      bin   = 8'd200;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (done) break;
         check("prot_busy", 32'(busy), 32'd1);
         start = (n == 2 || n == 9);
      end
      start = 1'b0;
      check("prot_latency", 32'(n), 32'd16);
      check("prot_bcd", 32'(bcd), 32'h042);
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done) dones++;
      end
      check("prot_no_second_done", 32'(dones), 32'd0);
      check("prot_idle", 32'(busy), 32'd0);

      // start held high: back-to-back restarts
      start = 1'b1;
      bin   = 8'd17;
      tick();
      bin = 8'd250;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (done) break;
      end
      check("b2b_first_latency", 32'(n), 32'd16);
      check("b2b_first_bcd", 32'(bcd), 32'h017);
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (done) break;
         check("b2b_bcd_hold", 32'(bcd), 32'h017);
         if (n == 2) start = 1'b0;
      end
      check("b2b_spacing", 32'(n), 32'd18);
      check("b2b_second_bcd", 32'(bcd), 32'h250);
      tick();
      tick();
      check("b2b_stop", 32'(busy), 32'd0);

      // mid-conversion reset
      start = 1'b1;
      bin   = 8'd123;
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_bcd", 32'(bcd), 32'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check("abort_bcd_after", 32'(bcd), 32'd0);
      convert8(8'd77, 12'h077, "b77");

      // 4-bit instance
      convert4(4'd9, 8'h09, "w4_9");
      convert4(4'd10, 8'h10, "w4_10");
      convert4(4'd15, 8'h15, "w4_15");
      convert4(4'd0, 8'h00, "w4_0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
